uart_receiver: RTL
==================

// Module: uart_receiver
// PURPOSE
//  Receive side of the UART peripheral: 16x-oversampled serial-to-parallel deserializer for uart_rx_i.
//  Frame format, baud divider and parity come from the uart_status_t fields; the UART top wires them in.
//  Each received frame is delivered as one data_valid_o pulse, with parity/framing flags, into the RX buffer.
//  Drives RTS from RX-buffer fullness when flow control is on.
// PARAMETERS
//  SYNC_STAGES    2    flip-flop stages synchronizing uart_rx_i (>=2)
// PORTS
//  clk_i            in   1   system clock
//  rst_i            in   1   reset, asynchronous, active-high
//  uart_rx_i        in   1   serial line, asynchronous, idle high
//  enable_i         in   1   enable_RX; low aborts/holds receiver in IDLE
//  clock_divider_i  in   15  tick period = clock_divider_i+1 clk cycles
//  data_bits_i      in   2   uart_data_lenght_t, DBIT5..DBIT8
//  stop_bits_i      in   1   uart_stop_bits_t
//  parity_mode_i    in   1   uart_parity_mode_t
//  parity_enable_i  in   1   parity bit expected after data
//  flow_control_i   in   1   enable RTS generation
//  buffer_full_i    in   1   RX buffer full
//  rts_n_o          out  1   ready-to-send, active-low
//  data_o           out  8   received data, zero-extended, LSB first on line
//  data_valid_o     out  1   1-cycle strobe, frame complete
//  parity_error_o   out  1   qualified by data_valid_o
//  frame_error_o    out  1   stop bit sampled 0; qualified by data_valid_o
//  busy_o           out  1   high whenever FSM != IDLE
// BEHAVIOUR
//  - Reset: data_o=0, data_valid_o=0, parity_error_o=0, frame_error_o=0, busy_o=0, rts_n_o=1; FSM=IDLE, counters 0.
//  - Tick generator: counter 0..clock_divider_i; tick on terminal count, then wraps to 0.
//    Cleared while enable_i=0 and on start-edge detection; baud = f_clk/((div+1)*16).
//  - rts_n_o = flow_control_i ? buffer_full_i : 0. Registered, 1-cycle latency.
//  - FSM IDLE: on synchronized 1->0 edge with enable_i=1: go START, clear tick and oversample counters.
//    Latch data_bits_i, stop_bits_i, parity_mode_i, parity_enable_i here; frame uses latched values.
//  - START: at oversample count 7 (bit middle), line 0 -> DATA, count=0; line 1 -> IDLE (glitch rejected, no output).
//  - DATA: sample at count 15 (mid of each bit); shift right into 8-bit register.
//    After 5+data_bits samples: go PARITY if parity enabled, else STOP.
//  - PARITY: sample at mid. Error if EVEN and ^{data,bit}!=0, or ODD and ^{data,bit}!=1.
//  - STOP: one or two stop bits, each sampled at mid. Any 0 sets frame error.
//    After the last stop sample: data_valid_o=1 for 1 clk, data_o/errors updated in the same cycle, FSM -> IDLE.
//    The next start edge is accepted from the following cycle.
//  - Errors do not suppress delivery; data_o holds its value until the next frame completes.
//  - enable_i falling mid-frame: next cycle FSM=IDLE, no strobe, data_o unchanged.
//  - Data-register alignment: for width<8, register is right-aligned so data_o[7:N]=0.
//  - Line stuck low after a frame (break): new START only on a fresh 1->0 edge.
// CONFIGURATION
//  UART_RX_MAJORITY_VOTE_EN defined:
//    every bit (start/data/parity/stop) = majority of samples at oversample counts 7,8,9 (relative to bit middle).
//    Decision taken at count 9.
//  Undefined:
//    single sample at the mid point only; no vote registers.
// STRUCTURE
//  uart_pkg gains: typedef enum uart_rx_fsm_t {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP};
//  uart_pkg gains: localparam UART_OVERSAMPLE = 16.
//  Sub-module baud_rate_generator (divider counter + tick); reused by the transmitter.
// TESTING
//  1 div=0, 8N1, send 0xA5 -> one data_valid_o, data_o=0xA5, both error flags 0,
//    strobe about 152 clk after the start edge.
//  2 7E1, send 0x35 with parity bit 1 (wrong) -> data_o=0x35, parity_error_o=1, frame_error_o=0.
//  3 8N1, drive stop bit 0 -> frame_error_o=1 with the strobe;
//    line back to 1, next frame 0x3C received clean.
//  4 Low pulse of 4 ticks on idle line -> no strobe, busy_o returns 0 after ~8 ticks.
//    Then 5N2 frame 0x1F -> data_o=0x1F.
//  5 enable_i dropped during data bit 3 -> busy_o=0 next cycle, no strobe.
//    flow_control_i=1, buffer_full_i=1 -> rts_n_o=1.
//  6 (macro on) 1-tick low glitch at mid of data bit 0 of 0xFF -> data_o=0xFF;
//    same stimulus with macro off -> data_o=0xFE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types: frame-format enums, receiver FSM states and oversampling constants.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [1:0] {DBIT5, DBIT6, DBIT7, DBIT8} uart_data_lenght_t;
    typedef enum logic {STOP1, STOP2} uart_stop_bits_t;
    typedef enum logic {PARITY_EVEN, PARITY_ODD} uart_parity_mode_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} uart_rx_fsm_t;

    typedef struct packed {
        uart_data_lenght_t data_bits;
        uart_stop_bits_t   stop_bits;
        uart_parity_mode_t parity_mode;
        logic              parity_enable;
    } uart_rx_cfg_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-to-RX-buffer delivery bus: frame strobe, data, error flags and RTS back-pressure.
interface uart_receiver_if;
    logic [7:0] data_o;
    logic       data_valid_o;
    logic       parity_error_o;
    logic       frame_error_o;
    logic       buffer_full_i;
    logic       rts_n_o;

    modport master (output data_o, data_valid_o, parity_error_o, frame_error_o, rts_n_o,
                    input  buffer_full_i);
    modport slave  (input  data_o, data_valid_o, parity_error_o, frame_error_o, rts_n_o,
                    output buffer_full_i);
endinterface

// File: rtl/baud_rate_generator.sv
// Divider counter producing a one-cycle tick every (divider_i+1) clocks; shared by RX and TX.
module baud_rate_generator (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic [14:0] divider_i,
    output logic        tick_o
);
    logic [14:0] cnt;
    logic        term;

    assign term   = (cnt >= divider_i);
    assign tick_o = !clear_i && term;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                 cnt <= '0;
        else if (clear_i || term)  cnt <= '0;
        else                       cnt <= cnt + 15'd1;
    end
endmodule

// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver. Define UART_RX_MAJORITY_VOTE_EN to decide each bit by a
// 3-sample majority around the bit middle instead of a single mid-bit sample.
module uart_receiver import uart_pkg::*; #(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              uart_rx_i,
    input  logic              enable_i,
    input  logic [14:0]       clock_divider_i,
    input  uart_data_lenght_t data_bits_i,
    input  uart_stop_bits_t   stop_bits_i,
    input  uart_parity_mode_t parity_mode_i,
    input  logic              parity_enable_i,
    input  logic              flow_control_i,
    output logic              busy_o,
    uart_receiver_if.master   rx_bus
);
    localparam int OS_W = $clog2(UART_OVERSAMPLE);
    localparam logic [OS_W-1:0] MID = OS_W'(UART_OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [OS_W-1:0] TAP1   = OS_W'(UART_OVERSAMPLE);
    localparam logic [OS_W-1:0] DECIDE = OS_W'(UART_OVERSAMPLE + 1);
`else
    localparam logic [OS_W-1:0] DECIDE = MID;
`endif

    logic [SYNC_STAGES-1:0] sync_q;
    logic rx_s, rx_prev;
    uart_rx_fsm_t state, state_nxt;
    uart_rx_cfg_t cfg;
    logic [OS_W-1:0] os_cnt, rel;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic par_acc, perr, ferr, stop_left;
    logic tick, start_det, decide, bit_val, last_data, deliver;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], uart_rx_i};
            rx_prev <= rx_s;
        end
    end
    assign rx_s = sync_q[SYNC_STAGES-1];

    baud_rate_generator u_baud (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (!enable_i || start_det),
        .divider_i (clock_divider_i),
        .tick_o    (tick)
    );

    // START counts from the falling edge, so shift it by half a bit to share DATA's phase.
    assign rel       = (state == RX_START) ? os_cnt + OS_W'(UART_OVERSAMPLE / 2) : os_cnt;
    assign start_det = (state == RX_IDLE) && enable_i && rx_prev && !rx_s;
    assign decide    = tick && (rel == DECIDE);
    assign last_data = (bit_cnt == 3'(cfg.data_bits) + 3'd4);

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] vote_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) vote_q <= '0;
        else if (tick) begin
            if (rel == MID)  vote_q[0] <= rx_s;
            if (rel == TAP1) vote_q[1] <= rx_s;
        end
    end
    assign bit_val = maj3(vote_q[0], vote_q[1], rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= RX_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        deliver   = 1'b0;
        case (state)
            RX_IDLE:   if (start_det) state_nxt = RX_START;
            RX_START:  if (decide) state_nxt = bit_val ? RX_IDLE : RX_DATA;
            RX_DATA:   if (decide && last_data) state_nxt = cfg.parity_enable ? RX_PARITY : RX_STOP;
            RX_PARITY: if (decide) state_nxt = RX_STOP;
            RX_STOP:   if (decide && !stop_left) begin
                           state_nxt = RX_IDLE;
                           deliver   = 1'b1;
                       end
            default:   state_nxt = RX_IDLE;
        endcase
        if (!enable_i) begin
            state_nxt = RX_IDLE;
            deliver   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg       <= '0;
            os_cnt    <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_acc   <= 1'b0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            stop_left <= 1'b0;
        end else begin
            if (start_det) begin
                cfg     <= '{data_bits: data_bits_i, stop_bits: stop_bits_i,
                             parity_mode: parity_mode_i, parity_enable: parity_enable_i};
                os_cnt  <= '0;
                bit_cnt <= '0;
                shreg   <= '0;
                par_acc <= 1'b0;
                perr    <= 1'b0;
                ferr    <= 1'b0;
            end else if (tick) begin
                os_cnt <= (state == RX_START && decide) ? rel + OS_W'(1) : os_cnt + OS_W'(1);
            end
            if (decide) begin
                case (state)
                    RX_DATA: begin
                        shreg   <= {bit_val, shreg[7:1]};
                        par_acc <= par_acc ^ bit_val;
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    RX_PARITY: perr <= ((par_acc ^ bit_val) != logic'(cfg.parity_mode));
                    RX_STOP: begin
                        ferr      <= ferr | !bit_val;
                        stop_left <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (state_nxt == RX_STOP && state != RX_STOP)
                stop_left <= (cfg.stop_bits == STOP2);
        end
    end

    // Short frames land in the top of shreg; shift down so unused high bits read 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_bus.data_o         <= '0;
            rx_bus.data_valid_o   <= 1'b0;
            rx_bus.parity_error_o <= 1'b0;
            rx_bus.frame_error_o  <= 1'b0;
            rx_bus.rts_n_o        <= 1'b1;
        end else begin
            rx_bus.data_valid_o <= deliver;
            if (deliver) begin
                rx_bus.data_o         <= shreg >> (2'd3 - 2'(cfg.data_bits));
                rx_bus.parity_error_o <= cfg.parity_enable & perr;
                rx_bus.frame_error_o  <= ferr | !bit_val;
            end
            rx_bus.rts_n_o <= flow_control_i ? rx_bus.buffer_full_i : 1'b0;
        end
    end

    assign busy_o = (state != RX_IDLE);

endmodule
